stream_demux_1x3: RTL and testbench



---
 rtl/demux_pkg.sv | 31 +++
 rtl/stream_demux_1x3_if.sv | 24 ++
 rtl/stream_skid_buffer.sv | 46 ++++
 rtl/stream_demux_1x3.sv | 75 +++++++
 tb/tb_stream_demux_1x3.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/demux_pkg.sv
// Shared select codes, channel count and beat layout for stream_demux_1x3.
// Optional drop counter is enabled by STREAM_DEMUX_DROP_CNT_EN.
package demux_pkg;

    localparam logic [1:0] SEL_CH0     = 2'b00;
    localparam logic [1:0] SEL_CH1     = 2'b01;
    localparam logic [1:0] SEL_CH2     = 2'b10;
    localparam logic [1:0] SEL_INVALID = 2'b11;

    localparam int NUM_CH       = 3;
    localparam int DATA_WIDTH_D = 32;

    typedef struct packed {
        logic [1:0]              sel;
        logic [DATA_WIDTH_D-1:0] data;
    } beat_t;

    // One-hot channel code for a select; zero for the invalid code.
    function automatic logic [NUM_CH-1:0] sel_onehot(input logic [1:0] sel);
        logic [NUM_CH-1:0] oh;
        oh = '0;
        case (sel)
            SEL_CH0: oh = 3'b001;
            SEL_CH1: oh = 3'b010;
            SEL_CH2: oh = 3'b100;
            default: oh = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/stream_demux_1x3_if.sv
// Producer and three-consumer handshake bundle of stream_demux_1x3.
// master = environment side, slave = demux side.
interface stream_demux_1x3_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            in_select;
    logic [DATA_WIDTH-1:0] in_data;
    logic [2:0]            out_valid;
    logic [2:0]            out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  sel_err;

    modport master (
        output in_valid, in_select, in_data, out_ready,
        input  in_ready, out_valid, out_data, sel_err
    );

    modport slave (
        input  in_valid, in_select, in_data, out_ready,
        output in_ready, out_valid, out_data, sel_err
    );
endinterface

// File: rtl/stream_skid_buffer.sv
// Generic two-entry (main + skid) valid/ready elastic stage.
// Ready toward the producer depends only on the skid register.
module stream_skid_buffer #(
    parameter int WIDTH = 34
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);
    logic             r_main_valid;
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_main_data;
    logic [WIDTH-1:0] r_skid_data;
    logic             w_fire;
    logic             w_drain;

    assign o_ready = ~r_skid_valid;
    assign o_valid = r_main_valid;
    assign o_data  = r_main_data;
    assign w_fire  = i_valid & ~r_skid_valid;
    assign w_drain = r_main_valid & i_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (r_skid_valid && w_drain) begin
            r_main_data  <= r_skid_data;
            r_skid_valid <= 1'b0;
        end else if (w_fire && (!r_main_valid || w_drain)) begin
            r_main_data  <= i_data;
            r_main_valid <= 1'b1;
        end else if (w_fire) begin
            // Main is stalled: park the beat so ready can drop registered.
            r_skid_data  <= i_data;
            r_skid_valid <= 1'b1;
        end else if (w_drain) begin
            r_main_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/stream_demux_1x3.sv
// Registered 1-to-3 stream demux; select 11 beats are accepted and dropped.
// Define STREAM_DEMUX_DROP_CNT_EN to add the saturating drop_cnt output.
module stream_demux_1x3
    import demux_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    stream_demux_1x3_if.slave    bus
`ifdef STREAM_DEMUX_DROP_CNT_EN
    ,
    output logic [7:0]           drop_cnt
`endif
);
    localparam int BW = DATA_WIDTH + 2;

    logic              w_sel_ok;
    logic              w_in_ready;
    logic              w_drop;
    logic              w_main_valid;
    logic [BW-1:0]     w_main;
    logic [1:0]        w_main_sel;
    logic [NUM_CH-1:0] w_ch;
    logic              w_out_ready;
    logic              r_sel_err;

    assign w_sel_ok   = (bus.in_select != SEL_INVALID);
    assign w_drop     = bus.in_valid & w_in_ready & ~w_sel_ok;
    assign w_main_sel = w_main[BW-1:DATA_WIDTH];

    stream_skid_buffer #(
        .WIDTH (BW)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .i_valid (bus.in_valid & w_sel_ok),
        .o_ready (w_in_ready),
        .i_data  ({bus.in_select, bus.in_data}),
        .o_valid (w_main_valid),
        .i_ready (w_out_ready),
        .o_data  (w_main)
    );

    always_comb begin
        w_ch        = sel_onehot(w_main_sel);
        w_out_ready = |(w_ch & bus.out_ready);
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_main_valid ? w_ch : '0;
    assign bus.out_data  = w_main[DATA_WIDTH-1:0];
    assign bus.sel_err   = r_sel_err;

    always_ff @(posedge clk) begin
        if (reset)
            r_sel_err <= 1'b0;
        else if (w_drop)
            r_sel_err <= 1'b1;
    end

`ifdef STREAM_DEMUX_DROP_CNT_EN
    logic [7:0] r_drop_cnt;

    always_ff @(posedge clk) begin
        if (reset)
            r_drop_cnt <= 8'd0;
        else if (w_drop && r_drop_cnt != 8'hFF)
            r_drop_cnt <= r_drop_cnt + 8'd1;
    end

    assign drop_cnt = r_drop_cnt;
`else
`endif
endmodule

// File: tb/tb_stream_demux_1x3.sv
// Directed self-checking bench for stream_demux_1x3.
// Drop-counter checks run when STREAM_DEMUX_DROP_CNT_EN is defined.
module tb_stream_demux_1x3;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;
`ifdef STREAM_DEMUX_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    stream_demux_1x3_if #(.DATA_WIDTH(32)) bus ();

    stream_demux_1x3 #(
        .DATA_WIDTH (32)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus)
`ifdef STREAM_DEMUX_DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] sel, input logic [31:0] d);
        bus.in_valid  = 1'b1;
        bus.in_select = sel;
        bus.in_data   = d;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_select = 2'b00;
        bus.in_data   = '0;
        bus.out_ready = 3'b000;

        // Reset and idle
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("rst_in_ready", 64'(bus.in_ready), 64'h1);
        check("rst_out_valid", 64'(bus.out_valid), 64'h0);
        check("rst_sel_err", 64'(bus.sel_err), 64'h0);
`ifdef STREAM_DEMUX_DROP_CNT_EN
        check("rst_drop_cnt", 64'(drop_cnt), 64'h0);
`endif

        // Streaming at full rate
        bus.out_ready = 3'b111;
        send(2'b00, 32'h11);
        tick();
        check("st0_valid", 64'(bus.out_valid), 64'h1);
        check("st0_data", 64'(bus.out_data), 64'h11);
        send(2'b01, 32'h22);
        tick();
        check("st1_valid", 64'(bus.out_valid), 64'h2);
        check("st1_data", 64'(bus.out_data), 64'h22);
        send(2'b10, 32'h33);
        tick();
        check("st2_valid", 64'(bus.out_valid), 64'h4);
        check("st2_data", 64'(bus.out_data), 64'h33);
        check("st2_in_ready", 64'(bus.in_ready), 64'h1);
        bus.in_valid = 1'b0;
        tick();
        check("st_empty", 64'(bus.out_valid), 64'h0);

        // Backpressure fills main then skid
        bus.out_ready = 3'b000;
        send(2'b01, 32'hA0);
        tick();
        check("bp_v0", 64'(bus.out_valid), 64'h2);
        check("bp_d0", 64'(bus.out_data), 64'hA0);
        check("bp_rdy0", 64'(bus.in_ready), 64'h1);
        send(2'b10, 32'hA1);
        tick();
        check("bp_rdy_full", 64'(bus.in_ready), 64'h0);
        check("bp_v_hold", 64'(bus.out_valid), 64'h2);
        check("bp_d_hold", 64'(bus.out_data), 64'hA0);
        bus.in_valid = 1'b0;
        bus.out_ready = 3'b100;
        tick();
        check("bp_wrong_rdy_v", 64'(bus.out_valid), 64'h2);
        check("bp_wrong_rdy_d", 64'(bus.out_data), 64'hA0);
        bus.out_ready = 3'b010;
        tick();
        check("bp_v1", 64'(bus.out_valid), 64'h4);
        check("bp_d1", 64'(bus.out_data), 64'hA1);
        check("bp_rdy_back", 64'(bus.in_ready), 64'h1);
        bus.out_ready = 3'b100;
        tick();
        check("bp_empty", 64'(bus.out_valid), 64'h0);

        // Invalid select between valid beats
        bus.out_ready = 3'b111;
        send(2'b00, 32'h55);
        tick();
        check("inv_v0", 64'(bus.out_valid), 64'h1);
        check("inv_d0", 64'(bus.out_data), 64'h55);
        check("inv_err0", 64'(bus.sel_err), 64'h0);
        send(2'b11, 32'hDEAD);
        tick();
        check("inv_drop_v", 64'(bus.out_valid), 64'h0);
        check("inv_err1", 64'(bus.sel_err), 64'h1);
`ifdef STREAM_DEMUX_DROP_CNT_EN
        check("inv_drop_cnt", 64'(drop_cnt), 64'h1);
`endif
        send(2'b01, 32'h66);
        tick();
        check("inv_v1", 64'(bus.out_valid), 64'h2);
        check("inv_d1", 64'(bus.out_data), 64'h66);
        check("inv_err_sticky", 64'(bus.sel_err), 64'h1);
        bus.in_valid = 1'b0;
        tick();
        check("inv_empty", 64'(bus.out_valid), 64'h0);
        check("inv_err_sticky2", 64'(bus.sel_err), 64'h1);

        // Reset while main and skid are both full
        bus.out_ready = 3'b000;
        send(2'b00, 32'h77);
        tick();
        send(2'b01, 32'h88);
        tick();
        check("mr_full", 64'(bus.in_ready), 64'h0);
        bus.in_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mr_v", 64'(bus.out_valid), 64'h0);
        check("mr_rdy", 64'(bus.in_ready), 64'h1);
        check("mr_err", 64'(bus.sel_err), 64'h0);
        bus.out_ready = 3'b111;
        tick();
        check("mr_gone0", 64'(bus.out_valid), 64'h0);
        tick();
        check("mr_gone1", 64'(bus.out_valid), 64'h0);

`ifdef STREAM_DEMUX_DROP_CNT_EN
        // Drop counter saturation
        check("sat_start", 64'(drop_cnt), 64'h0);
        send(2'b11, 32'hBAD);
        for (int i = 0; i < 260; i++) begin
            tick();
            check("sat_in_ready", 64'(bus.in_ready), 64'h1);
        end
        bus.in_valid = 1'b0;
        tick();
        check("sat_cnt", 64'(drop_cnt), 64'hFF);
        check("sat_no_out", 64'(bus.out_valid), 64'h0);
`else
        check("nodrop_err", 64'(bus.sel_err), 64'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
